// File: rtl/dsp_mac_sequencer.sv
// Dot-product sequencer for one DSP slice built with A1REG=B1REG=MREG=PREG=OPMODEREG=1.
// Streams signed (a,b) pairs into the slice and captures the 48-bit accumulated P.
module dsp_mac_sequencer #(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 3,
  parameter int OPM_DLY  = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_p,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_p
);

  localparam int DCNT_W = $clog2(PIPE_LAT + 1);

  localparam logic [7:0] OPM_CLR  = 8'h00;
  localparam logic [7:0] OPM_MUL  = 8'h01;
  localparam logic [7:0] OPM_HOLD = 8'h08;
  localparam logic [7:0] OPM_MAC  = 8'h09;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic               first_q, first_d;
  logic [47:0]        res_p_q, res_p_d;
  logic               busy_q, busy_d;
  logic               in_ready_q, in_ready_d;
  logic               res_valid_q, res_valid_d;
  logic               dsp_ce_q, dsp_ce_d;
  logic [7:0]         opm_q [OPM_DLY];
  logic [7:0]         opm_issue_s;
  logic               beat_s;

  assign beat_s     = in_valid & in_ready_q;
  assign dsp_a      = beat_s ? in_a : 18'd0;
  assign dsp_b      = beat_s ? in_b : 18'd0;
  assign dsp_rst    = RST;
  assign dsp_opmode = opm_q[OPM_DLY-1];
  assign busy       = busy_q;
  assign in_ready   = in_ready_q;
  assign res_valid  = res_valid_q;
  assign res_p      = res_p_q;
  assign dsp_ce     = dsp_ce_q;

  // State register, job counters, registered outputs and the OPMODE delay line
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= {LEN_W{1'b0}};
      dcnt_q      <= {DCNT_W{1'b0}};
      first_q     <= 1'b0;
      res_p_q     <= 48'd0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      dsp_ce_q    <= 1'b0;
      for (int i = 0; i < OPM_DLY; i++) begin
        opm_q[i] <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      first_q     <= first_d;
      res_p_q     <= res_p_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      dsp_ce_q    <= dsp_ce_d;
      opm_q[0]    <= opm_issue_s;
      for (int i = 1; i < OPM_DLY; i++) begin
        opm_q[i] <= opm_q[i-1];
      end
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    first_d = first_q;
    res_p_d = res_p_q;
    case (state_q)
      S_IDLE: begin
        if (start && (len != {LEN_W{1'b0}})) begin
          state_d = S_RUN;
          cnt_d   = len;
          first_d = 1'b1;
        end else if (start) begin
          state_d = S_DONE;
          res_p_d = 48'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (beat_s) begin
          cnt_d   = cnt_q - LEN_W'(1);
          first_d = 1'b0;
          if (cnt_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
            dcnt_d  = DCNT_W'(PIPE_LAT);
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        dcnt_d = dcnt_q - DCNT_W'(1);
        // P now reflects the last beat: it has crossed A1, M and P registers
        if (dcnt_q == DCNT_W'(1)) begin
          res_p_d = dsp_p;
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: registered strobes follow state_d, OPMODE follows the current beat
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    in_ready_d  = (state_d == S_RUN);
    res_valid_d = (state_d == S_DONE);
    dsp_ce_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
    opm_issue_s = OPM_CLR;
    case (state_q)
      S_RUN: begin
        if (beat_s) begin
          opm_issue_s = first_q ? OPM_MUL : OPM_MAC;
        end else begin
          opm_issue_s = first_q ? OPM_CLR : OPM_HOLD;
        end
      end
      S_DRAIN: begin
        opm_issue_s = OPM_HOLD;
      end
      default: begin
        opm_issue_s = OPM_CLR;
      end
    endcase
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP slice and a result scoreboard.
module tb_dsp_mac_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        in_valid = 1'b0;
  logic [17:0] in_a = 18'd0;
  logic [17:0] in_b = 18'd0;
  logic        res_ready = 1'b0;
  logic        busy, in_ready, res_valid, dsp_ce, dsp_rst;
  logic [47:0] res_p, dsp_p;
  logic [17:0] dsp_a, dsp_b;
  logic [7:0]  dsp_opmode;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [47:0] exp_q [$];
  logic [47:0] acc = 48'd0;
  logic [47:0] last_exp = 48'd0;

  dsp_mac_sequencer dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
    .dsp_ce(dsp_ce), .dsp_rst(dsp_rst), .dsp_p(dsp_p)
  );

  always #5 CLK = ~CLK;

  // Behavioural DSP slice: A1/B1 -> M -> P, OPMODE registered, X=M when [1:0]=01, Z=P when [3:2]=10
  logic signed [17:0] a1_r, b1_r;
  logic signed [35:0] prod_s;
  logic        [47:0] m_r, p_r;
  logic        [7:0]  opm_r;
  assign prod_s = a1_r * b1_r;
  assign dsp_p  = p_r;
  always @(posedge CLK) begin
    if (dsp_rst) begin
      a1_r <= 18'sd0; b1_r <= 18'sd0; m_r <= 48'd0; p_r <= 48'd0; opm_r <= 8'h00;
    end else if (dsp_ce) begin
      a1_r  <= dsp_a;
      b1_r  <= dsp_b;
      m_r   <= {{12{prod_s[35]}}, prod_s};
      opm_r <= dsp_opmode;
      p_r   <= ((opm_r[1:0] == 2'b01) ? m_r : 48'd0) + ((opm_r[3:2] == 2'b10) ? p_r : 48'd0);
    end
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [7:0] l);
    @(negedge CLK);
    start = 1'b1; len = l; acc = 48'd0;
    @(negedge CLK);
    start = 1'b0;
    #1;
    check("start_busy", 48'(busy), 48'(1'b1));
    check("start_in_ready", 48'(in_ready), 48'(l != 8'd0));
  endtask

  task automatic send_pair(input logic [17:0] a, input logic [17:0] b, input int gap, input logic first);
    @(negedge CLK);
    in_valid = 1'b1; in_a = a; in_b = b;
    #1;
    check("beat_in_ready", 48'(in_ready), 48'(1'b1));
    check("beat_dsp_a", 48'(dsp_a), 48'(a));
    check("beat_dsp_b", 48'(dsp_b), 48'(b));
    acc = acc + ($signed({{30{a[17]}}, a}) * $signed({{30{b[17]}}, b}));
    for (int g = 0; g < gap; g++) begin
      @(negedge CLK);
      in_valid = 1'b0;
      #1;
      check("gap_dsp_a", 48'(dsp_a), 48'd0);
      check("gap_opmode", 48'(dsp_opmode), (g == 0) ? (first ? 48'h01 : 48'h09) : 48'h08);
      check("gap_busy", 48'(busy), 48'(1'b1));
    end
  endtask

  // Called right after a back-to-back final beat; measures beat-to-res_valid latency
  task automatic finish_job(input int exp_lat);
    int lat;
    lat = 21;
    exp_q.push_back(acc);
    @(posedge CLK);
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      in_valid = 1'b0; in_a = 18'd0; in_b = 18'd0;
      #1;
      check("drain_busy", 48'(busy), 48'(1'b1));
      if (res_valid) begin
        lat = k;
        break;
      end else begin
        check("drain_ce", 48'(dsp_ce), 48'(1'b1));
        check("drain_in_ready", 48'(in_ready), 48'(1'b0));
      end
    end
    check("res_latency", 48'(lat), 48'(exp_lat));
    last_exp = exp_q.pop_front();
    check("res_p", res_p, last_exp);
    check("done_ce", 48'(dsp_ce), 48'(1'b0));
  endtask

  task automatic handshake();
    @(negedge CLK);
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    #1;
    check("hs_res_valid", 48'(res_valid), 48'(1'b0));
    check("hs_busy", 48'(busy), 48'(1'b0));
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(negedge CLK);
    #1;
    check("rst_busy", 48'(busy), 48'(1'b0));
    check("rst_in_ready", 48'(in_ready), 48'(1'b0));
    check("rst_res_valid", 48'(res_valid), 48'(1'b0));
    check("rst_ce", 48'(dsp_ce), 48'(1'b0));
    check("rst_res_p", res_p, 48'd0);
    check("rst_opmode", 48'(dsp_opmode), 48'h00);
    check("rst_dsp_rst", 48'(dsp_rst), 48'(1'b1));
    RST = 1'b0;
    #1;
    check("rst_release", 48'(dsp_rst), 48'(1'b0));

    // Back-to-back dot product: 6+20-7 = 19
    start_job(8'd3);
    send_pair(18'd2, 18'd3, 0, 1'b1);
    send_pair(18'd4, 18'd5, 0, 1'b0);
    send_pair(-18'sd1, 18'd7, 0, 1'b0);
    finish_job(4);
    check("t2_const", res_p, 48'd19);
    handshake();

    // Same data with two idle cycles between beats
    start_job(8'd3);
    send_pair(18'd2, 18'd3, 2, 1'b1);
    send_pair(18'd4, 18'd5, 2, 1'b0);
    send_pair(-18'sd1, 18'd7, 0, 1'b0);
    finish_job(4);
    check("t3_const", res_p, 48'd19);
    handshake();

    // Zero-length job finishes immediately without touching the DSP
    @(negedge CLK);
    in_a = 18'd5; in_b = 18'd5;
    start = 1'b1; len = 8'd0;
    exp_q.push_back(48'd0);
    @(negedge CLK);
    start = 1'b0;
    #1;
    check("len0_res_valid", 48'(res_valid), 48'(1'b1));
    check("len0_res_p", res_p, exp_q.pop_front());
    check("len0_ce", 48'(dsp_ce), 48'(1'b0));
    check("len0_dsp_a", 48'(dsp_a), 48'd0);
    handshake();

    // Most negative operands: 2 * 2^34
    start_job(8'd2);
    send_pair(18'h20000, 18'h20000, 0, 1'b1);
    send_pair(18'h20000, 18'h20000, 0, 1'b0);
    finish_job(4);
    check("t5_const", res_p, 48'h0008_0000_0000);

    // Result held under backpressure while start is ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      start = 1'b1; len = 8'd3;
      #1;
      check("bp_res_valid", 48'(res_valid), 48'(1'b1));
      check("bp_res_p", res_p, last_exp);
      check("bp_in_ready", 48'(in_ready), 48'(1'b0));
    end
    @(negedge CLK);
    start = 1'b0;
    handshake();
    start_job(8'd1);
    send_pair(18'd6, 18'd7, 0, 1'b1);
    finish_job(4);
    check("t6_const", res_p, 48'd42);
    handshake();

    // Reset mid-run aborts the job
    start_job(8'd5);
    send_pair(18'd1, 18'd1, 0, 1'b1);
    send_pair(18'd2, 18'd2, 0, 1'b0);
    @(negedge CLK);
    in_valid = 1'b0; RST = 1'b1;
    #1;
    check("abort_dsp_rst", 48'(dsp_rst), 48'(1'b1));
    @(negedge CLK);
    #1;
    check("abort_dsp_rst2", 48'(dsp_rst), 48'(1'b1));
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("abort_busy", 48'(busy), 48'(1'b0));
    check("abort_in_ready", 48'(in_ready), 48'(1'b0));
    check("abort_res_valid", 48'(res_valid), 48'(1'b0));
    check("abort_opmode", 48'(dsp_opmode), 48'h00);
    check("abort_dsp_rst0", 48'(dsp_rst), 48'(1'b0));

    // Recovery job after abort: 3 * -4 = -12
    start_job(8'd1);
    send_pair(18'd3, -18'sd4, 0, 1'b1);
    finish_job(4);
    check("recover_const", res_p, 48'hFFFF_FFFF_FFF4);
    handshake();

    check("scoreboard_empty", 48'(exp_q.size()), 48'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
